// File: rtl/spi_master_v4_param_if.sv
// Bus bundle for spi_master_v4_param: command-side request/response plus the SPI pins.
// Build option SPI_LOOPBACK_EN adds the loopback request input.
interface spi_master_v4_param_if #(
    parameter int DATA_W = 16,
    parameter int NUM_CS = 2
);
    localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    // Handshake: start is a one-cycle request taken only when busy=0 and cs_sel<NUM_CS;
    // every taken request is answered by exactly one cycle with rx_valid=tx_done=1.
    // The result side has no ready: rx_data simply holds until the next rx_valid.
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic [CSW-1:0]    cs_sel;
    logic              cpol;
    logic              cpha;
    logic              lsb_first;
    logic [1:0]        freq_control;
    logic              miso;
    logic              sclk;
    logic              mosi;
    logic [NUM_CS-1:0] cs_n;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              tx_done;
    logic              busy;

`ifdef SPI_LOOPBACK_EN
    logic              loopback;

    modport master (
        input  start, tx_data, cs_sel, cpol, cpha, lsb_first, freq_control, miso, loopback,
        output sclk, mosi, cs_n, rx_data, rx_valid, tx_done, busy
    );
    modport slave (
        output start, tx_data, cs_sel, cpol, cpha, lsb_first, freq_control, miso, loopback,
        input  sclk, mosi, cs_n, rx_data, rx_valid, tx_done, busy
    );
`else
    modport master (
        input  start, tx_data, cs_sel, cpol, cpha, lsb_first, freq_control, miso,
        output sclk, mosi, cs_n, rx_data, rx_valid, tx_done, busy
    );
    modport slave (
        output start, tx_data, cs_sel, cpol, cpha, lsb_first, freq_control, miso,
        input  sclk, mosi, cs_n, rx_data, rx_valid, tx_done, busy
    );
`endif
endinterface

// File: rtl/spi_master_v4_param.sv
// Parametrised SPI master: all CPOL/CPHA modes, MSB/LSB first, one-hot selects, 4 SCLK dividers.
// Build option SPI_LOOPBACK_EN: latched loopback routes mosi back into the receiver.
module spi_master_v4_param #(
    parameter int DATA_W = 16,
    parameter int NUM_CS = 2,
    parameter int DIV0   = 0,
    parameter int DIV1   = 1,
    parameter int DIV2   = 4,
    parameter int DIV3   = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    spi_master_v4_param_if.master bus,
    output logic [2:0]            dbg_state_o
);
    localparam int CSW   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int MAX01 = (DIV0 > DIV1) ? DIV0 : DIV1;
    localparam int MAX23 = (DIV2 > DIV3) ? DIV2 : DIV3;
    localparam int MAXD  = (MAX01 > MAX23) ? MAX01 : MAX23;
    localparam int CNT_W = (MAXD > 0) ? $clog2(MAXD + 1) : 1;
    localparam int EW    = $clog2(2 * DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_XFER  = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [EW-1:0]     edge_q;
    logic [DATA_W-1:0] tx_sr_q;
    logic [DATA_W-1:0] rx_sr_q;
    logic [DATA_W-1:0] rx_data_q;
    logic [1:0]        freq_q;
    logic              cpha_q;
    logic              lsb_q;
    logic              lb_q;
    logic              sclk_q;
    logic              mosi_q;
    logic [NUM_CS-1:0] cs_n_q;
    logic              rx_valid_q;
    logic              tx_done_q;
    logic              busy_q;
    logic              rx_bit_w;
    logic              start_ok_w;
    logic              sample_w;
    logic              last_edge_w;

    function automatic logic [CNT_W-1:0] div_of(input logic [1:0] f);
        case (f)
            2'd0:    return CNT_W'(DIV0);
            2'd1:    return CNT_W'(DIV1);
            2'd2:    return CNT_W'(DIV2);
            default: return CNT_W'(DIV3);
        endcase
    endfunction

    function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    // Receive direction mirrors transmit so rx_data always lands in natural bit order.
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] sr, input logic b,
                                                   input logic lsb);
        return lsb ? {b, sr[DATA_W-1:1]} : {sr[DATA_W-2:0], b};
    endfunction

`ifdef SPI_LOOPBACK_EN
    assign rx_bit_w = lb_q ? mosi_q : bus.miso;
`else
    assign lb_q     = 1'b0;
    assign rx_bit_w = bus.miso;
`endif

    assign start_ok_w  = bus.start && (int'(bus.cs_sel) < NUM_CS);
    // Upcoming edge number is edge_q+1: odd edges lead. CPHA=0 samples on leading edges.
    assign sample_w    = ~edge_q[0] ^ cpha_q;
    assign last_edge_w = (edge_q == EW'(2 * DATA_W - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            edge_q     <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            freq_q     <= 2'd0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
`ifdef SPI_LOOPBACK_EN
            lb_q       <= 1'b0;
`endif
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= '1;
            rx_valid_q <= 1'b0;
            tx_done_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    sclk_q <= bus.cpol;
                    if (start_ok_w) begin
                        state_q <= S_SETUP;
                        cnt_q   <= div_of(bus.freq_control);
                        edge_q  <= '0;
                        freq_q  <= bus.freq_control;
                        cpha_q  <= bus.cpha;
                        lsb_q   <= bus.lsb_first;
`ifdef SPI_LOOPBACK_EN
                        lb_q    <= bus.loopback;
`endif
                        rx_sr_q <= '0;
                        cs_n_q  <= ~(NUM_CS'(1) << bus.cs_sel);
                        busy_q  <= 1'b1;
                        if (!bus.cpha) begin
                            mosi_q  <= first_bit(bus.tx_data, bus.lsb_first);
                            tx_sr_q <= shift_out(bus.tx_data, bus.lsb_first);
                        end else begin
                            tx_sr_q <= bus.tx_data;
                        end
                    end
                end
                S_SETUP, S_XFER: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        cnt_q <= div_of(freq_q);
                        if (edge_q == EW'(2 * DATA_W)) begin
                            state_q <= S_HOLD;
                        end else begin
                            state_q <= S_XFER;
                            sclk_q  <= ~sclk_q;
                            edge_q  <= edge_q + EW'(1);
                            if (sample_w) begin
                                rx_sr_q <= shift_in(rx_sr_q, rx_bit_w, lsb_q);
                            end else if (!last_edge_w) begin
                                mosi_q  <= first_bit(tx_sr_q, lsb_q);
                                tx_sr_q <= shift_out(tx_sr_q, lsb_q);
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q    <= S_DONE;
                        cs_n_q     <= '1;
                        rx_data_q  <= rx_sr_q;
                        rx_valid_q <= 1'b1;
                        tx_done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    rx_valid_q <= 1'b0;
                    tx_done_q  <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sclk     = sclk_q;
    assign bus.mosi     = mosi_q;
    assign bus.cs_n     = cs_n_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.tx_done  = tx_done_q;
    assign bus.busy     = busy_q;
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_spi_master_v4_param.sv
// Self-checking bench for spi_master_v4_param: a bus-level slave/monitor model checks every
// cycle of every transfer; directed cases pin the model, then randomized transfers follow.
module tb_spi_master_v4_param;
    localparam int DW  = 16;
    localparam int NCS = 3;

    logic       clk;
    logic       reset;
    logic [2:0] dbg_state;

    spi_master_v4_param_if #(.DATA_W(DW), .NUM_CS(NCS)) bus ();

    spi_master_v4_param #(.DATA_W(DW), .NUM_CS(NCS)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [DW-1:0] tx;
        logic [DW-1:0] sw;
        logic [1:0]    cs;
        logic          cpol;
        logic          cpha;
        logic          lsb;
        int            h;
    } xfer_t;

    xfer_t         cfg_q[$];
    logic [DW-1:0] exp_q[$];
    int            total = 0;
    int            bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int bitpos(input int i, input logic lsb);
        return lsb ? i : DW - 1 - i;
    endfunction

    function automatic int half_of(input logic [1:0] f);
        case (f)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 5;
            default: return 25;
        endcase
    endfunction

    // ---------------- slave model + per-cycle compare ----------------
    xfer_t         cur;
    logic          active = 1'b0;
    int            low_cnt, edges, sidx, mbits;
    logic [DW-1:0] mword;
    logic          prev_sclk = 1'b0;
    logic [DW-1:0] last_mosi_word;
    int            last_low_cnt, last_edges;
    logic          last_first_mosi, first_mosi;
    logic [NCS-1:0] last_cs_n;
    logic [NCS-1:0] exp_cs;
    logic [DW-1:0]  exp_rx;

    always @(negedge clk) begin
        if (!reset) begin
            active = 1'b0;
        end else if (active) begin
            if (bus.cs_n === '1) begin
                chk("xfer_len", low_cnt, (2 * DW + 2) * cur.h);
                chk("edge_count", edges, 2 * DW);
                chk("done_rx_valid", bus.rx_valid, 1);
                chk("done_tx_done", bus.tx_done, 1);
                chk("done_busy", bus.busy, 1);
                chk("done_sclk", bus.sclk, cur.cpol);
                chk("mosi_word", mword, cur.tx);
                if (exp_q.size() == 0) begin
                    chk("exp_q_empty", 1, 0);
                end else begin
                    exp_rx = exp_q.pop_front();
                    chk("rx_data", bus.rx_data, exp_rx);
                end
                last_mosi_word  = mword;
                last_low_cnt    = low_cnt;
                last_edges      = edges;
                last_first_mosi = first_mosi;
                active          = 1'b0;
            end else begin
                low_cnt++;
                exp_cs = ~(NCS'(1) << cur.cs);
                chk("cs_n_xfer", bus.cs_n, exp_cs);
                chk("busy_xfer", bus.busy, 1);
                chk("pulse_xfer", {bus.rx_valid, bus.tx_done}, 0);
                if (bus.sclk !== prev_sclk) begin
                    edges++;
                    chk("edge_time", low_cnt, edges * cur.h + 1);
                    if (((edges % 2) == 1) != cur.cpha) begin
                        if (mbits == 0) first_mosi = bus.mosi;
                        if (mbits < DW) mword[bitpos(mbits, cur.lsb)] = bus.mosi;
                        mbits++;
                    end else if (sidx < DW) begin
                        bus.miso = cur.sw[bitpos(sidx, cur.lsb)];
                        sidx++;
                    end
                end else if (edges == 0 || edges == 2 * DW) begin
                    chk("sclk_idle", bus.sclk, cur.cpol);
                end
            end
        end else begin
            if (bus.cs_n !== '1) begin
                if (cfg_q.size() == 0) begin
                    chk("unexpected_xfer", bus.cs_n, '1);
                end else begin
                    cur     = cfg_q.pop_front();
                    active  = 1'b1;
                    low_cnt = 1;
                    edges   = 0;
                    sidx    = 0;
                    mbits   = 0;
                    mword   = '0;
                    exp_cs  = ~(NCS'(1) << cur.cs);
                    last_cs_n = bus.cs_n;
                    chk("cs_n_start", bus.cs_n, exp_cs);
                    chk("busy_start", bus.busy, 1);
                    chk("sclk_start", bus.sclk, cur.cpol);
                    if (!cur.cpha) begin
                        bus.miso = cur.sw[bitpos(0, cur.lsb)];
                        sidx     = 1;
                    end
                end
            end else begin
                chk("idle_pulse", {bus.rx_valid, bus.tx_done}, 0);
                chk("idle_busy", bus.busy, 0);
            end
        end
        prev_sclk = bus.sclk;
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [DW-1:0] tx, input logic [DW-1:0] sw, input logic [1:0] cs,
                         input logic cp, input logic ph, input logic lsb, input logic [1:0] f,
                         input logic lb);
        xfer_t x;
        x.tx = tx; x.sw = sw; x.cs = cs; x.cpol = cp; x.cpha = ph; x.lsb = lsb; x.h = half_of(f);
        cfg_q.push_back(x);
        exp_q.push_back(lb ? tx : sw);
        bus.tx_data      = tx;
        bus.cs_sel       = cs;
        bus.cpol         = cp;
        bus.cpha         = ph;
        bus.lsb_first    = lsb;
        bus.freq_control = f;
`ifdef SPI_LOOPBACK_EN
        bus.loopback     = lb;
`endif
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // mode 0: plain, 1: extra start while busy, 2: extra start during the done cycle
    task automatic run_xfer(input logic [DW-1:0] tx, input logic [DW-1:0] sw, input logic [1:0] cs,
                            input logic cp, input logic ph, input logic lsb, input logic [1:0] f,
                            input logic lb, input int mode);
        int n;
        issue(tx, sw, cs, cp, ph, lsb, f, lb);
        if (mode == 1) begin
            repeat (4) @(posedge clk);
            #1;
            bus.tx_data = ~tx;
            bus.cs_sel  = 2'd2;
            bus.start   = 1'b1;
            @(posedge clk); #1;
            bus.start   = 1'b0;
        end
        n = 0;
        while (bus.tx_done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", n < 3000, 1);
        if (mode == 2) begin
            bus.cs_sel = 2'd0;
            bus.start  = 1'b1;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.start = 1'b0; bus.tx_data = '0; bus.cs_sel = '0; bus.cpol = 1'b0; bus.cpha = 1'b0;
        bus.lsb_first = 1'b0; bus.freq_control = 2'd0; bus.miso = 1'b0;
`ifdef SPI_LOOPBACK_EN
        bus.loopback = 1'b0;
`endif
        reset = 1'b0;
        #12;
        chk("rst_cs_n", bus.cs_n, 3'b111);
        chk("rst_sclk", bus.sclk, 0);
        chk("rst_mosi", bus.mosi, 0);
        chk("rst_rx_data", bus.rx_data, 0);
        chk("rst_pulses", {bus.rx_valid, bus.tx_done}, 0);
        chk("rst_busy", bus.busy, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // mode 0, fastest divider
        run_xfer(16'h55AA, 16'hA55A, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 0);
        chk("t2_rx_data", bus.rx_data, 16'hA55A);
        chk("t2_mosi", last_mosi_word, 16'h55AA);
        chk("t2_cs_low_cycles", last_low_cnt, 34);

        // all four modes at divider 2
        for (int m = 0; m < 4; m++) begin
            run_xfer(16'h1234, 16'($urandom), 2'd1, m[1], m[0], 1'b0, 2'd2, 1'b0, 0);
            chk("t3_mosi", last_mosi_word, 16'h1234);
            chk("t3_edges", last_edges, 32);
        end

        // LSB first
        run_xfer(16'h0001, 16'h0001, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 0);
        chk("t4_first_mosi", last_first_mosi, 1);
        chk("t4_rx_data", bus.rx_data, 16'h0001);

        // select 1, plus an extra start while busy
        run_xfer(16'hC3A5, 16'h0F0F, 2'd1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1);
        chk("t5_cs_n", last_cs_n, 3'b101);
        chk("t5_rx_data", bus.rx_data, 16'h0F0F);

        // out-of-range select is ignored
        bus.cs_sel = 2'd3;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("t5_bad_sel_busy", bus.busy, 0);
        chk("t5_bad_sel_cs_n", bus.cs_n, 3'b111);

        // start during the done cycle is ignored
        run_xfer(16'h8001, 16'h7FFE, 2'd2, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 2);

        // randomized transfers
        for (int i = 0; i < 16; i++) begin
            run_xfer(16'($urandom), 16'($urandom), 2'($urandom_range(0, NCS - 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)), 1'b0, $urandom_range(0, 2));
        end

`ifdef SPI_LOOPBACK_EN
        run_xfer(16'hABCD, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 0);
        chk("t6_loopback_rx", bus.rx_data, 16'hABCD);
`endif
        chk("queue_drained", exp_q.size(), 0);

        // async reset in the middle of a slow transfer
        issue(16'hBEEF, 16'h1357, 2'd2, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0);
        repeat (300) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("t1_cs_n", bus.cs_n, 3'b111);
        chk("t1_sclk", bus.sclk, 0);
        chk("t1_busy", bus.busy, 0);
        chk("t1_rx_valid", bus.rx_valid, 0);
        cfg_q.delete();
        exp_q.delete();
        bus.cpol = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("t1_rx_data_cleared", bus.rx_data, 0);
        chk("t1_no_pulse", bus.rx_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
